// File: rtl/lfsr8_sequence_checker.sv
// Self-synchronising checker for the x^8 + x^6 + x^5 + x^4 + 1 sequence.
// It fills a local register from the stream, verifies predictions until
// LOCK_COUNT consecutive matches, then flywheels and counts bits and errors
// until UNLOCK_COUNT consecutive misses force a resync.
module lfsr8_sequence_checker #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic                 bit_in,
  input  logic                 clear_counts,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_COUNT - 1);

  state_t     st;
  logic [8:1] r;           // r[1] is the newest bit
  logic [2:0] fill;
  logic [7:0] match_cnt;
  logic [3:0] miss_cnt;

  logic       expected;
  logic       mismatch;
  logic       shift_in;
  logic [8:1] r_next;
  logic       count_en;
  logic       err_en;

  // Prediction, comparison and next register value for the current sample
  always_comb begin
    expected = r[8] ^ r[6] ^ r[5] ^ r[4];
    mismatch = bit_in ^ expected;
    // Once locked the register runs on its own prediction so received
    // errors cannot corrupt it.
    shift_in = (st == LOCKED) ? expected : bit_in;
    r_next   = {r[7:1], shift_in};
    count_en = valid_in && (st == LOCKED);
    err_en   = count_en && mismatch;
  end

  // Synchronisation FSM with its shift register, internal counters and flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= SEARCH;
      r           <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
    end else begin
      error_pulse <= 1'b0;
      if (valid_in) begin
        r <= r_next;
        case (st)
          SEARCH: begin
            if (fill == 3'd7) begin
              st        <= VERIFY;
              fill      <= '0;
              match_cnt <= '0;
            end else begin
              fill <= fill + 3'd1;
            end
          end
          VERIFY: begin
            // All-zero is the lock-up state; it is rejected ahead of any match.
            if (r_next == '0) begin
              st        <= SEARCH;
              fill      <= '0;
              match_cnt <= '0;
            end else if (mismatch) begin
              match_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              st        <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end
          LOCKED: begin
            if (mismatch) begin
              error_pulse <= 1'b1;
              if (miss_cnt == UNLOCK_LAST) begin
                st       <= SEARCH;
                locked   <= 1'b0;
                fill     <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            st     <= SEARCH;
            locked <= 1'b0;
            fill   <= '0;
          end
        endcase
      end
    end
  end

  // Saturating status counters; a clear overrides a coincident increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_count   <= '0;
      error_count <= '0;
    end else if (clear_counts) begin
      bit_count   <= '0;
      error_count <= '0;
    end else begin
      if (count_en && (bit_count != '1)) bit_count <= bit_count + 1'b1;
      if (err_en && (error_count != '1)) error_count <= error_count + 1'b1;
    end
  end

  assign state = st;

endmodule

// File: doc/lfsr8_sequence_checker.md
# lfsr8_sequence_checker

Serial checker for the 8-bit pseudo-random sequence (polynomial X^8 + X^6 + X^5 + X^4 + 1). It sits directly downstream of the 8-bit linear feedback shift register and consumes one generated bit per qualified clock. It self-synchronises to the incoming stream, declares lock, and then counts checked bits and bit errors for link/BIST status.

## Interface
- LOCK_COUNT, 16: consecutive correct predictions needed in VERIFY to enter LOCKED (legal range 1..255).
- UNLOCK_COUNT, 4: consecutive mismatches in LOCKED that drop back to SEARCH (legal range 1..15).
- CNT_WIDTH, 16: width of both status counters.
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- valid_in  input  1  qualifies bit_in this cycle; nothing advances when low.
- bit_in  input  1  newest sequence bit (the generator's feedback bit for that step).
- clear_counts  input  1  synchronous clear of bit_count and error_count.
- locked  output  1  high while in LOCKED.
- error_pulse  output  1  one-cycle pulse per mismatch detected in LOCKED.
- bit_count  output  CNT_WIDTH  valid bits checked while LOCKED, saturating.
- error_count  output  CNT_WIDTH  mismatches while LOCKED, saturating.
- state  output  2  SEARCH=0, VERIFY=1, LOCKED=2 (3 unused, decodes as SEARCH).

## Operation
- Local register r[1:8], r[1] newest. Expected bit e = r[8]^r[6]^r[5]^r[4]. Each qualified sample shifts: r <= {x, r[1:7]}.
- SEARCH: x = bit_in. A fill counter counts 8 qualified samples, then the block goes to VERIFY with the match counter at 0.
- VERIFY: x = bit_in; compare bit_in with e.
  - Match: increment the match counter. When it reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: the match counter goes to 0 and the state stays VERIFY. The register already holds the newest 8 received bits, so no refill is done.
  - If r is all-zero after the shift, the block goes to SEARCH with fill = 0. All-zero is the lock-up state and is never accepted.
- LOCKED: x = e (flywheel; received errors do not corrupt the prediction).
  - Each qualified sample increments bit_count.
  - Mismatch: error_pulse = 1, error_count +1, miss counter +1. Match: miss counter goes to 0.
  - When the miss counter reaches UNLOCK_COUNT, go to SEARCH with fill = 0 and miss = 0.
- Counters saturate at all-ones and never wrap.
- clear_counts zeroes both counters. If it coincides with an increment, the clear wins (result 0). It does not affect the state.
- valid_in low: no state, register, counter or pulse change. error_pulse = 0.

## Timing
- All outputs are registered. Reset values: locked = 0, error_pulse = 0, bit_count = 0, error_count = 0, state = SEARCH, r = 0, internal counters = 0.
- Reset mid-operation forces the reset values asynchronously. The first sample accepted after deassertion is fill sample 1.
- error_pulse, counter updates, and state changes are visible on the edge that samples the triggering bit, so they appear in the following cycle.
- Minimum time to lock from reset on a clean stream: 8 + LOCK_COUNT qualified samples. With defaults this is 24. locked is high after the 24th sampling edge.
- Unlock after UNLOCK_COUNT consecutive errors: locked falls on the same edge that produces the final error_pulse.
- Throughput: one bit per clock. valid_in may toggle arbitrarily.

## Test plan
- Clean stream from a generator seeded r[1:8]=00000111, valid_in continuously high -> state 0→1 after 8 samples, locked = 1 after 24 samples; after a further 1000 samples, bit_count = 1000 and error_count = 0.
- Same stream, valid_in toggling every other cycle -> lock after 24 valid samples (48 clocks); counters advance only on valid cycles.
- Locked, invert 3 isolated bits spaced at least 20 samples apart -> exactly 3 error_pulses, error_count = 3, locked stays 1.
- Locked, invert 4 consecutive bits -> 4 pulses, error_count = 4, state = SEARCH on the 4th edge; relock 24 samples later.
- All-zero input for 50 samples -> never leaves SEARCH/VERIFY, locked = 0.
- error_count preset to 0xFFFF via forced errors, further errors -> count stays 0xFFFF. clear_counts simultaneous with an error -> 0. Async reset asserted mid-lock -> all outputs at reset values in the same cycle.
